// File: rtl/common_lib_pseudo_reverse_buf.sv
// Ping-pong reorder buffer: writes each beat at pseudo_rev(k, step) and reads addresses in natural order.
// Optional macro COMMON_LIB_PSEUDO_REVERSE_BUF_OUT_REG_EN adds a 2-entry output skid register after the read.
module common_lib_pseudo_reverse_buf #(
    parameter int S      = 4,
    parameter int B      = 2,
    parameter int DATA_W = 32,
    localparam int B_W   = $clog2(B),
    localparam int S_W   = $clog2(S),
    localparam int ADD_W = S * B_W,
    localparam int N     = 1 << ADD_W
) (
    input  logic              clk,
    input  logic              a_rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic [S_W-1:0]    in_step,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic [S_W-1:0]    out_step,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_vld,
    input  logic              out_rdy
);
    localparam int IDX_W = S_W + 1;

    typedef enum logic [1:0] {EMPTY, FILL, FULL} bank_state_t;

    bank_state_t       state_reg [2];
    logic [S_W-1:0]    step_reg [2];
    logic              wr_bank_reg, rd_bank_reg;
    logic [ADD_W-1:0]  wr_cnt_reg, rd_cnt_reg;
    logic [DATA_W-1:0] mem [2*N];

    logic              wr_acc, rd_acc, m_vld, m_rdy;
    logic [S_W-1:0]    step_in_c, step_eff;
    logic [ADD_W-1:0]  wr_addr;
    logic [B_W-1:0]    wr_dig [S];
    logic [DATA_W-1:0] rd_data;

    // Out-of-range steps collapse to S-1, which is the identity mapping.
    assign step_in_c = (in_step > S_W'(S - 1)) ? S_W'(S - 1) : in_step;
    assign step_eff  = (wr_cnt_reg == '0) ? step_in_c : step_reg[wr_bank_reg];

    genvar gi;
    generate
        for (gi = 0; gi < S; gi++) begin : g_dig
            logic [IDX_W-1:0] src;
            assign wr_dig[gi] = wr_cnt_reg[gi*B_W +: B_W];
            assign src = (IDX_W'(gi) < {1'b0, step_eff}) ? IDX_W'(gi)
                                                         : IDX_W'(S - 1 - gi) + {1'b0, step_eff};
            assign wr_addr[gi*B_W +: B_W] = wr_dig[src[S_W-1:0]];
        end
    endgenerate

    assign in_rdy = (state_reg[wr_bank_reg] != FULL);
    assign wr_acc = in_vld & in_rdy;
    assign m_vld  = (state_reg[rd_bank_reg] == FULL);
    assign rd_acc = m_vld & m_rdy;

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            for (int b = 0; b < 2; b++) begin
                state_reg[b] <= EMPTY;
                step_reg[b]  <= '0;
            end
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            wr_cnt_reg  <= '0;
            rd_cnt_reg  <= '0;
        end else begin
            // Write and read banks never coincide: one is FULL, the other is not.
            if (wr_acc) begin
                if (wr_cnt_reg == '0)
                    step_reg[wr_bank_reg] <= step_in_c;
                if (wr_cnt_reg == '1) begin
                    state_reg[wr_bank_reg] <= FULL;
                    wr_bank_reg            <= ~wr_bank_reg;
                    wr_cnt_reg             <= '0;
                end else begin
                    state_reg[wr_bank_reg] <= FILL;
                    wr_cnt_reg             <= wr_cnt_reg + 1'b1;
                end
            end
            if (rd_acc) begin
                if (rd_cnt_reg == '1) begin
                    state_reg[rd_bank_reg] <= EMPTY;
                    rd_bank_reg            <= ~rd_bank_reg;
                    rd_cnt_reg             <= '0;
                end else begin
                    rd_cnt_reg <= rd_cnt_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[{wr_bank_reg, wr_addr}] <= in_data;
    end

    assign rd_data = mem[{rd_bank_reg, rd_cnt_reg}];

`ifdef COMMON_LIB_PSEUDO_REVERSE_BUF_OUT_REG_EN
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [S_W-1:0]    step;
        logic              sop;
        logic              eop;
    } beat_t;

    beat_t skid_reg [2];
    beat_t rd_beat;
    logic  skid_v0_reg, skid_v1_reg;
    logic  push, pop;

    assign rd_beat = {rd_data, step_reg[rd_bank_reg], rd_cnt_reg == '0, rd_cnt_reg == '1};
    assign m_rdy   = ~skid_v1_reg;
    assign push    = rd_acc;
    assign pop     = skid_v0_reg & out_rdy;

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            skid_v0_reg <= 1'b0;
            skid_v1_reg <= 1'b0;
        end else if (push && !pop) begin
            if (!skid_v0_reg) skid_v0_reg <= 1'b1;
            else              skid_v1_reg <= 1'b1;
        end else if (pop && !push) begin
            skid_v0_reg <= skid_v1_reg;
            skid_v1_reg <= 1'b0;
        end
    end

    // Push implies the second slot is free, so push+pop always lands in slot 0.
    always_ff @(posedge clk) begin
        if (push && pop)
            skid_reg[0] <= rd_beat;
        else if (push) begin
            if (!skid_v0_reg) skid_reg[0] <= rd_beat;
            else              skid_reg[1] <= rd_beat;
        end else if (pop)
            skid_reg[0] <= skid_reg[1];
    end

    assign out_vld  = skid_v0_reg;
    assign out_data = skid_reg[0].data;
    assign out_step = skid_reg[0].step;
    assign out_sop  = skid_v0_reg & skid_reg[0].sop;
    assign out_eop  = skid_v0_reg & skid_reg[0].eop;
`else
    assign m_rdy    = out_rdy;
    assign out_vld  = m_vld;
    assign out_data = rd_data;
    assign out_step = step_reg[rd_bank_reg];
    assign out_sop  = m_vld & (rd_cnt_reg == '0);
    assign out_eop  = m_vld & (rd_cnt_reg == '1);
`endif

endmodule

// File: tb/tb_common_lib_pseudo_reverse_buf.sv
// Randomised bench for common_lib_pseudo_reverse_buf against a frame-level permutation model.
module tb_common_lib_pseudo_reverse_buf;
    localparam int S = 4;
    localparam int B = 2;
    localparam int DATA_W = 32;
    localparam int S_W = 2;
    localparam int N = 16;

    logic              clk = 1'b0;
    logic              a_rst;
    logic [DATA_W-1:0] in_data;
    logic [S_W-1:0]    in_step;
    logic              in_vld;
    logic              in_rdy;
    logic [DATA_W-1:0] out_data;
    logic [S_W-1:0]    out_step;
    logic              out_sop, out_eop, out_vld;
    logic              out_rdy;

    int checks = 0;
    int failures = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

    common_lib_pseudo_reverse_buf #(.S(S), .B(B), .DATA_W(DATA_W)) dut (
        .clk(clk), .a_rst(a_rst),
        .in_data(in_data), .in_step(in_step), .in_vld(in_vld), .in_rdy(in_rdy),
        .out_data(out_data), .out_step(out_step), .out_sop(out_sop), .out_eop(out_eop),
        .out_vld(out_vld), .out_rdy(out_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [S_W-1:0]    st;
        int                idx;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] part[$];
    logic [S_W-1:0]    part_step;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Digit-wise definition of the permutation, straight from base-B arithmetic.
    function automatic int prev(input int k, input int st);
        int r, src, dig;
        r = 0;
        for (int s = 0; s < S; s++) begin
            src = (s < st) ? s : S - 1 - (s - st);
            dig = (k / (B ** src)) % B;
            r = r + dig * (B ** s);
        end
        return r;
    endfunction

    task automatic pin(input string nm, input int st, input int lit[16]);
        int nat[16];
        for (int k = 0; k < N; k++) nat[prev(k, st)] = k;
        for (int j = 0; j < N; j++) chk(nm, 64'(nat[j]), 64'(lit[j]));
    endtask

    // Monitor: checks outputs against the model, then applies this cycle's handshakes.
    logic              hold_prev = 1'b0;
    logic [DATA_W-1:0] data_prev;
    logic [S_W-1:0]    step_prev;
    logic              sop_prev, eop_prev;
    exp_t              e;
    logic [DATA_W-1:0] nat_fr [N];
    logic              exp_vld;

    always @(negedge clk) begin
        if (a_rst) begin
            chk("rst_out_vld", 64'(out_vld), 64'd0);
            chk("rst_in_rdy", 64'(in_rdy), 64'd1);
            chk("rst_sop_eop", 64'({out_sop, out_eop}), 64'd0);
            exp_q.delete();
            part.delete();
            hold_prev = 1'b0;
        end else begin
            exp_vld = (exp_q.size() > 0);
            chk("out_vld", 64'(out_vld), 64'(exp_vld));
            chk("in_rdy", 64'(in_rdy), 64'(exp_q.size() <= N));
            if (exp_vld) begin
                e = exp_q[0];
                chk("out_sop", 64'(out_sop), 64'(e.idx == 0));
                chk("out_eop", 64'(out_eop), 64'(e.idx == N - 1));
                chk("out_data", 64'(out_data), 64'(e.d));
                chk("out_step", 64'(out_step), 64'(e.st));
            end else begin
                chk("idle_sop_eop", 64'({out_sop, out_eop}), 64'd0);
            end
            if (hold_prev && out_vld)
                chk("stall_stable", 64'({out_data, out_step, out_sop, out_eop}),
                    64'({data_prev, step_prev, sop_prev, eop_prev}));
            hold_prev = out_vld & ~out_rdy;
            data_prev = out_data; step_prev = out_step;
            sop_prev = out_sop;   eop_prev = out_eop;

            if (out_vld && out_rdy && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_vld && in_rdy) begin
                if (part.size() == 0) part_step = in_step;
                part.push_back(in_data);
                if (part.size() == N) begin
                    for (int k = 0; k < N; k++) nat_fr[prev(k, int'(part_step))] = part[k];
                    for (int j = 0; j < N; j++) begin
                        e.d = nat_fr[j]; e.st = part_step; e.idx = j;
                        exp_q.push_back(e);
                    end
                    part.delete();
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        out_rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        in_vld  = 1'b0;
        in_data = $urandom;
        in_step = S_W'($urandom);
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic [S_W-1:0] st);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        while (!acc) begin
            in_vld = 1'b1; in_data = d; in_step = st;
            @(negedge clk);
            acc = in_rdy;
            cyc();
            n++;
            if (!acc && n > 500) begin
                chk("in_rdy_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic send_frame(input logic [S_W-1:0] st, input bit rnd_data, input bit gaps);
        for (int k = 0; k < N; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) cyc();
            send_beat(rnd_data ? DATA_W'($urandom) : DATA_W'(k), st);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 2000) begin cyc(); n++; end
        if (exp_q.size() > 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int lit0[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        int lit2[16] = '{0, 1, 2, 3, 8, 9, 10, 11, 4, 5, 6, 7, 12, 13, 14, 15};
        int lit3[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
        pin("model_step0", 0, lit0);
        pin("model_step2", 2, lit2);
        pin("model_step3", 3, lit3);

        a_rst = 1'b1; in_vld = 1'b0; in_data = '0; in_step = '0; out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 a_rst = 1'b0;
        cyc();

        send_frame(2'd0, 0, 0); drain();
        send_frame(2'd2, 0, 0); drain();
        send_frame(2'd3, 0, 0); drain();

        rdy_mode = 2;
        send_frame(2'd0, 0, 0);
        send_frame(2'd2, 0, 0);
        repeat (3) cyc();
        rdy_mode = 0;
        send_frame(2'd3, 0, 0);
        drain();

        rdy_mode = 1;
        for (int f = 0; f < 10; f++) send_frame(S_W'($urandom_range(0, S - 1)), 1, 1);
        drain();

        rdy_mode = 0;
        for (int k = 0; k < 7; k++) send_beat(DATA_W'(100 + k), 2'd1);
        @(posedge clk);
        #1 a_rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 a_rst = 1'b0;
        cyc();
        send_frame(2'd0, 0, 0);
        drain();
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
